// File: rtl/debug_ctrl_pkg.sv
// Shared definitions for the debug run controller: state encoding, key polarity
// and the run-rate period table.
package debug_ctrl_pkg;

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_CYC   = 2'd1,
        S_INSTR = 2'd2,
        S_RUN   = 2'd3
    } run_state_t;

    // Debounced keys pulse low for one clk.
    localparam logic KEY_ACTIVE = 1'b0;

    // log2 of the run period for a rate select: 8*sel, capped at the divider width.
    function automatic int period_log2(input logic [1:0] sel, input int div_w);
        int sh;
        sh = 8 * int'(sel);
        return (sh > div_w) ? div_w : sh;
    endfunction

endpackage

// File: rtl/debug_run_ctrl_if.sv
// Key, CPU-handshake and status bundle of the run controller; the bp_* members
// exist only when BREAKPOINT_EN is defined.
interface debug_run_ctrl_if #(
    parameter int PC_W = 32
);
    logic            key_step_n;
    logic            key_instr_n;
    logic            key_run_n;
    logic [1:0]      div_sel;
    logic            cpu_instr_done;
    logic [PC_W-1:0] cpu_pc;
    logic            cpu_clk_en;
    logic            halted;
    logic [1:0]      state_o;
    logic [15:0]     step_cnt;
    logic            timeout;
`ifdef BREAKPOINT_EN
    logic [PC_W-1:0] bp_addr;
    logic            bp_valid;
    logic            bp_hit;

    modport master (
        input  key_step_n, key_instr_n, key_run_n, div_sel, cpu_instr_done, cpu_pc,
        input  bp_addr, bp_valid,
        output cpu_clk_en, halted, state_o, step_cnt, timeout, bp_hit
    );
    modport slave (
        output key_step_n, key_instr_n, key_run_n, div_sel, cpu_instr_done, cpu_pc,
        output bp_addr, bp_valid,
        input  cpu_clk_en, halted, state_o, step_cnt, timeout, bp_hit
    );
`else
    modport master (
        input  key_step_n, key_instr_n, key_run_n, div_sel, cpu_instr_done, cpu_pc,
        output cpu_clk_en, halted, state_o, step_cnt, timeout
    );
    modport slave (
        output key_step_n, key_instr_n, key_run_n, div_sel, cpu_instr_done, cpu_pc,
        input  cpu_clk_en, halted, state_o, step_cnt, timeout
    );
`endif
endinterface

// File: rtl/run_rate_div.sv
// Free-run rate divider: counts 0..period-1 and flags, one edge early, the clk
// on which the count will sit at period-1 so the caller can register its enable.
module run_rate_div
    import debug_ctrl_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    input  logic       clear,
    input  logic [1:0] div_sel,
    output logic       tick_next
);
    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [1:0]       sel_reg;
    logic [DIV_W-1:0] count_reg;
    logic [DIV_W-1:0] count_next;
    logic [DIV_W-1:0] last_cur;
    logic [DIV_W-1:0] last_new;

    function automatic logic [DIV_W-1:0] last_of(input logic [1:0] sel);
        return {DIV_W{1'b1}} >> (DIV_W - period_log2(sel, DIV_W));
    endfunction

    assign last_cur = last_of(sel_reg);
    assign last_new = last_of(div_sel);

    always_comb begin
        count_next = count_reg;
        tick_next  = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next = '0;
            tick_next  = (last_new == '0);
        end else if (advance) begin
            count_next = (count_reg == last_cur) ? '0 : count_reg + ONE;
            tick_next  = (count_next == last_cur);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            sel_reg   <= 2'd0;
        end else begin
            count_reg <= count_next;
            // Rate is frozen for the whole run; only a fresh RUN entry picks up div_sel.
            if (load) begin
                sel_reg <= div_sel;
            end
        end
    end

endmodule

// File: rtl/debug_run_ctrl.sv
// Run controller for the multi-cycle CPU: halt / clock step / instruction step /
// free run via cpu_clk_en. Optional breakpoint in RUN under BREAKPOINT_EN.
module debug_run_ctrl
    import debug_ctrl_pkg::*;
#(
    parameter int DIV_W = 24,
    parameter int TO_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    debug_run_ctrl_if.master  bus
);
    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    run_state_t      state_reg;
    logic            cpu_clk_en_reg;
    logic            halted_reg;
    logic [15:0]     step_cnt_reg;
    logic            timeout_reg;
    logic [TO_W-1:0] to_cnt_reg;

    logic run_key;
    logic instr_key;
    logic step_key;
    logic any_key;
    logic bp_fire;
    logic div_load;
    logic div_clear;
    logic div_advance;
    logic div_tick;

    assign run_key   = (bus.key_run_n   == KEY_ACTIVE);
    assign instr_key = (bus.key_instr_n == KEY_ACTIVE);
    assign step_key  = (bus.key_step_n  == KEY_ACTIVE);
    assign any_key   = run_key | instr_key | step_key;

`ifdef BREAKPOINT_EN
    logic bp_hit_reg;
    assign bp_fire = (state_reg == S_RUN) && cpu_clk_en_reg && bus.cpu_instr_done &&
                     bus.bp_valid && (bus.cpu_pc == bus.bp_addr);
    assign bus.bp_hit = bp_hit_reg;
`else
    assign bp_fire = 1'b0;
`endif

    assign div_load    = (state_reg == S_HALT) && run_key;
    assign div_advance = (state_reg == S_RUN);
    assign div_clear   = (state_reg == S_RUN) && (run_key || bp_fire);

    run_rate_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .advance   (div_advance),
        .clear     (div_clear),
        .div_sel   (bus.div_sel),
        .tick_next (div_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_HALT;
            cpu_clk_en_reg <= 1'b0;
            halted_reg     <= 1'b1;
            step_cnt_reg   <= 16'd0;
            timeout_reg    <= 1'b0;
            to_cnt_reg     <= '0;
`ifdef BREAKPOINT_EN
            bp_hit_reg     <= 1'b0;
`endif
        end else begin
            if (cpu_clk_en_reg && bus.cpu_instr_done) begin
                step_cnt_reg <= step_cnt_reg + 16'd1;
            end
            case (state_reg)
                S_HALT: begin
                    if (any_key) begin
                        timeout_reg <= 1'b0;
`ifdef BREAKPOINT_EN
                        bp_hit_reg  <= 1'b0;
`endif
                    end
                    if (run_key) begin
                        state_reg      <= S_RUN;
                        halted_reg     <= 1'b0;
                        cpu_clk_en_reg <= div_tick;
                    end else if (instr_key) begin
                        state_reg      <= S_INSTR;
                        halted_reg     <= 1'b0;
                        cpu_clk_en_reg <= 1'b1;
                        to_cnt_reg     <= '0;
                    end else if (step_key) begin
                        state_reg      <= S_CYC;
                        halted_reg     <= 1'b0;
                        cpu_clk_en_reg <= 1'b1;
                    end
                end
                S_INSTR: begin
                    // Every INSTR clk is enabled, so done here is always a real completion.
                    if (run_key || bus.cpu_instr_done) begin
                        state_reg      <= S_HALT;
                        halted_reg     <= 1'b1;
                        cpu_clk_en_reg <= 1'b0;
                    end else if (to_cnt_reg == TO_LAST) begin
                        state_reg      <= S_HALT;
                        halted_reg     <= 1'b1;
                        cpu_clk_en_reg <= 1'b0;
                        timeout_reg    <= 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_ONE;
                    end
                end
                S_RUN: begin
                    if (run_key || bp_fire) begin
                        state_reg      <= S_HALT;
                        halted_reg     <= 1'b1;
                        cpu_clk_en_reg <= 1'b0;
`ifdef BREAKPOINT_EN
                        bp_hit_reg     <= !run_key;
`endif
                    end else begin
                        cpu_clk_en_reg <= div_tick;
                    end
                end
                default: begin
                    state_reg      <= S_HALT;
                    halted_reg     <= 1'b1;
                    cpu_clk_en_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_clk_en = cpu_clk_en_reg;
    assign bus.halted     = halted_reg;
    assign bus.state_o    = state_reg;
    assign bus.step_cnt   = step_cnt_reg;
    assign bus.timeout    = timeout_reg;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Bench for debug_run_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_debug_run_ctrl;
    localparam int DIV_W = 12;
    localparam int TO_W  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_run_ctrl_if #(.PC_W(32)) bus();

    debug_run_ctrl #(
        .DIV_W (DIV_W),
        .TO_W  (TO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: mode 0=halt 1=cyc 2=instr 3=run
    int m_mode, m_step, m_j, m_period, m_n;
    bit m_en, m_to, m_bp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int period_of(input int sel);
        int sh;
        sh = 8 * sel;
        if (sh > DIV_W) sh = DIV_W;
        return 1 << sh;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_en = 0; m_step = 0; m_to = 0; m_bp = 0;
        m_j = 0; m_period = 1; m_n = 0;
    endtask

    task automatic model_edge();
        bit r, i, s, d;
        r = (bus.key_run_n == 1'b0);
        i = (bus.key_instr_n == 1'b0);
        s = (bus.key_step_n == 1'b0);
        d = (bus.cpu_instr_done == 1'b1);
        if (m_en && d) m_step = (m_step + 1) % 65536;
        case (m_mode)
            0: begin
                if (r || i || s) begin m_to = 0; m_bp = 0; end
                if (r) begin m_mode = 3; m_period = period_of(int'(bus.div_sel)); m_j = 0; end
                else if (i) begin m_mode = 2; m_n = 0; end
                else if (s) m_mode = 1;
            end
            1: m_mode = 0;
            2: begin
                m_n++;
                if (r || d) m_mode = 0;
                else if (m_n == (1 << TO_W) - 1) begin m_mode = 0; m_to = 1; end
            end
            default: begin
                if (r) m_mode = 0;
`ifdef BREAKPOINT_EN
                else if (m_en && d && bus.bp_valid && bus.cpu_pc == bus.bp_addr) begin
                    m_mode = 0; m_bp = 1;
                end
`endif
                else m_j++;
            end
        endcase
        m_en = (m_mode == 1) || (m_mode == 2) || (m_mode == 3 && ((m_j + 1) % m_period == 0));
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (rst !== 1'b1) model_reset();
            else model_edge();
        end
    end

    // Compare every cycle while out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                check("cpu_clk_en", 32'(bus.cpu_clk_en), 32'(m_en));
                check("state_o", 32'(bus.state_o), 32'(m_mode));
                check("halted", 32'(bus.halted), 32'(m_mode == 0));
                check("step_cnt", 32'(bus.step_cnt), 32'(m_step));
                check("timeout", 32'(bus.timeout), 32'(m_to));
`ifdef BREAKPOINT_EN
                check("bp_hit", 32'(bus.bp_hit), 32'(m_bp));
`endif
            end
        end
    end

    task automatic press(input bit r, input bit i, input bit s);
        @(negedge clk);
        bus.key_run_n      = !r;
        bus.key_instr_n    = !i;
        bus.key_step_n     = !s;
        bus.cpu_instr_done = 1'b0;
    endtask

    // Run n cycles, counting enabled clks; raise done on the done_at-th enabled clk.
    task automatic cycles(input int n, input int done_at, output int en_cnt, output int first_en);
        en_cnt = 0;
        first_en = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.key_run_n = 1'b1; bus.key_instr_n = 1'b1; bus.key_step_n = 1'b1;
            bus.cpu_instr_done = 1'b0;
            if (bus.cpu_clk_en === 1'b1) begin
                if (first_en < 0) first_en = k;
                en_cnt++;
                if (done_at > 0 && en_cnt == done_at) bus.cpu_instr_done = 1'b1;
            end
        end
    endtask

    int c, f;

    initial begin
        rst = 1'b0;
        bus.key_run_n = 1'b1; bus.key_instr_n = 1'b1; bus.key_step_n = 1'b1;
        bus.div_sel = 2'd0; bus.cpu_instr_done = 1'b0; bus.cpu_pc = 32'h0;
`ifdef BREAKPOINT_EN
        bus.bp_addr = 32'h40; bus.bp_valid = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_halted", 32'(bus.halted), 32'd1);
        check("reset_step_cnt", 32'(bus.step_cnt), 32'd0);

        // Single clock step
        press(0, 0, 1);
        cycles(6, 0, c, f);
        check("cyc_en_count", 32'(c), 32'd1);
        check("cyc_first_en", 32'(f), 32'd0);

        // Instruction step, done on 5th enabled clk
        press(0, 1, 0);
        cycles(10, 5, c, f);
        check("instr_en_count", 32'(c), 32'd5);
        check("instr_step_cnt", 32'(bus.step_cnt), 32'd1);
        check("instr_back_halt", 32'(bus.state_o), 32'd0);

        // Instruction step timeout, then a step key clears timeout
        press(0, 1, 0);
        cycles(25, 0, c, f);
        check("to_en_count", 32'(c), 32'd15);
        check("to_flag", 32'(bus.timeout), 32'd1);
        check("to_halted", 32'(bus.halted), 32'd1);
        press(0, 0, 1);
        cycles(4, 0, c, f);
        check("to_cleared", 32'(bus.timeout), 32'd0);
        check("to_step_en", 32'(c), 32'd1);

        // Run at 256-clk period; rate change mid-run has no effect
        bus.div_sel = 2'd1;
        press(1, 0, 0);
        cycles(300, 0, c, f);
        check("run_en_count", 32'(c), 32'd1);
        check("run_first_en", 32'(f), 32'd255);
        bus.div_sel = 2'd0;
        cycles(300, 0, c, f);
        check("run_sel_ignored_count", 32'(c), 32'd1);
        check("run_sel_ignored_at", 32'(f), 32'd211);
        press(1, 0, 0);
        cycles(3, 0, c, f);
        check("run_halt", 32'(bus.state_o), 32'd0);
        check("run_halt_en", 32'(c), 32'd0);
        bus.div_sel = 2'd1;
        press(1, 0, 1);
        cycles(1, 0, c, f);
        check("run_step_prio", 32'(bus.state_o), 32'd3);
        press(1, 0, 0);
        cycles(2, 0, c, f);

        // Period-1 run, then asynchronous reset mid-run
        bus.div_sel = 2'd0;
        press(1, 0, 0);
        cycles(6, 3, c, f);
        check("run1_en_count", 32'(c), 32'd6);
        check("run1_step_cnt", 32'(bus.step_cnt), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_en", 32'(bus.cpu_clk_en), 32'd0);
        check("arst_halted", 32'(bus.halted), 32'd1);
        check("arst_state", 32'(bus.state_o), 32'd0);
        check("arst_step_cnt", 32'(bus.step_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

`ifdef BREAKPOINT_EN
        bus.bp_valid = 1'b1;
        bus.cpu_pc = 32'h40;
        press(1, 0, 0);
        cycles(1, 1, c, f);
        cycles(2, 0, c, f);
        check("bp_state", 32'(bus.state_o), 32'd0);
        check("bp_hit_flag", 32'(bus.bp_hit), 32'd1);
        check("bp_step_cnt", 32'(bus.step_cnt), 32'd1);
`endif

        // Randomized phase
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            bus.key_run_n   = ($urandom_range(0, 24) != 0);
            bus.key_instr_n = ($urandom_range(0, 15) != 0);
            bus.key_step_n  = ($urandom_range(0, 15) != 0);
            bus.cpu_instr_done = 1'($urandom_range(0, 2) == 0);
            bus.div_sel = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
`ifdef BREAKPOINT_EN
            bus.bp_valid = 1'($urandom_range(0, 1));
            bus.cpu_pc = ($urandom_range(0, 3) == 0) ? 32'h40 : 32'h44;
`endif
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
